// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_pkg
//  Description : Shared types for the dense layer datapath (vector type,
//                sequencer state encoding, activation helper).
//  Revision    : 1.0  initial release
// ============================================================================
package nn_pkg;

    localparam int N_OUT_DEFAULT = 10;

    typedef int vec_t [N_OUT_DEFAULT];

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        BIAS  = 3'd4,
        HOLD  = 3'd5
    } seq_state_e;

    function automatic int relu(input int x);
        return (x < 0) ? 0 : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dense_mac_array.sv
`default_nettype none
// ============================================================================
//  Module      : dense_mac_array
//  Description : N_OUT parallel 32-bit wrapping multiply-accumulate lanes
//                sharing one activation operand.
//  Revision    : 1.0  initial release
// ============================================================================
module dense_mac_array
    import nn_pkg::*;
#(
    parameter int N_OUT = N_OUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    input  int   a,
    input  int   b   [N_OUT],
    output int   acc [N_OUT]
);

    // Products and sums are truncated to 32 bits; overflow wraps silently.
    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
        always_ff @(posedge clk) begin
            if (rst || clear) begin
                acc[j] <= 0;
            end else if (en) begin
                acc[j] <= acc[j] + a * b[j];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dense_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dense_layer_sequencer
//  Description : Sequences one fully connected layer: streams inputs/weights,
//                accumulates, gates the external bias adder, holds the result.
//                Optional ReLU on capture: define DENSE_SEQ_RELU_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module dense_layer_sequencer
    import nn_pkg::*;
#(
    parameter int N_IN   = 784,
    parameter int N_OUT  = N_OUT_DEFAULT,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] rd_addr,
    input  int                in_data,
    input  int                w_data    [N_OUT],
    output int                acc       [N_OUT],
    output logic              adder_rst,
    input  int                biased    [N_OUT],
    output int                result    [N_OUT],
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(N_IN - 1);

    seq_state_e r_state;
    seq_state_e w_state_next;
    logic       r_rd_vld;
    logic       w_last_addr;

    assign w_last_addr = (rd_addr == C_LAST_ADDR);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = CLEAR;
            CLEAR:   w_state_next = RUN;
            RUN:     if (w_last_addr) w_state_next = DRAIN;
            DRAIN:   w_state_next = BIAS;
            BIAS:    w_state_next = HOLD;
            HOLD:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign busy      = (r_state != IDLE);
    assign adder_rst = (r_state != BIAS);
    assign out_valid = (r_state == HOLD);
    assign done      = (r_state == HOLD) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            rd_addr  <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                CLEAR: begin
                    rd_addr  <= '0;
                    r_rd_vld <= 1'b0;
                end
                RUN: begin
                    r_rd_vld <= 1'b1;
                    // Address parks on the last index so it holds outside RUN.
                    if (!w_last_addr) begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                DRAIN: r_rd_vld <= 1'b0;
                default: ;
            endcase
        end
    end

    // Memory data lags the address by one cycle, so accumulation follows rd_vld.
    dense_mac_array #(
        .N_OUT (N_OUT)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clear (r_state == CLEAR),
        .en    (r_rd_vld),
        .a     (in_data),
        .b     (w_data),
        .acc   (acc)
    );

    for (genvar j = 0; j < N_OUT; j++) begin : g_capture
        always_ff @(posedge clk) begin
            if (rst) begin
                result[j] <= 0;
            end else if (r_state == BIAS) begin
`ifdef DENSE_SEQ_RELU_EN
                result[j] <= relu(biased[j]);
`else
                result[j] <= biased[j];
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dense_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dense_layer_sequencer
//  Description : Directed self-checking bench with memory and bias adder models.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dense_layer_sequencer;
    import nn_pkg::*;

    localparam int N_IN   = 4;
    localparam int N_OUT  = 10;
    localparam int ADDR_W = 16;
`ifdef DENSE_SEQ_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              out_ready = 1'b0;
    logic              busy, adder_rst, out_valid, done;
    logic [ADDR_W-1:0] rd_addr;
    int                in_data;
    int                w_data  [N_OUT];
    int                acc     [N_OUT];
    int                biased  [N_OUT];
    int                result  [N_OUT];

    int in_mem  [N_IN];
    int w_mem   [N_IN][N_OUT];
    int bias    [N_OUT];
    int exp_res [N_OUT];

    int tests = 0;
    int fails = 0;
    int lat;

    always #5 clk = ~clk;

    dense_layer_sequencer #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .rd_addr   (rd_addr),
        .in_data   (in_data),
        .w_data    (w_data),
        .acc       (acc),
        .adder_rst (adder_rst),
        .biased    (biased),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done)
    );

    // Synchronous input buffer and weight ROM, one-cycle read latency.
    always @(posedge clk) begin
        in_data <= in_mem[rd_addr[1:0]];
        for (int j = 0; j < N_OUT; j++) w_data[j] <= w_mem[rd_addr[1:0]][j];
    end

    // External combinational bias adder.
    always_comb begin
        for (int j = 0; j < N_OUT; j++) biased[j] = adder_rst ? 0 : acc[j] + bias[j];
    end

    function automatic int act(input int v);
        return (RELU && v < 0) ? 0 : v;
    endfunction

    task automatic clear_vectors();
        for (int k = 0; k < N_IN; k++) begin
            in_mem[k] = 0;
            for (int j = 0; j < N_OUT; j++) w_mem[k][j] = 0;
        end
        for (int j = 0; j < N_OUT; j++) begin
            bias[j]    = 0;
            exp_res[j] = 0;
        end
    endtask

    // Basic vectors: acc = {30,-30,0..}, bias = {5,5,0..}.
    task automatic load_basic();
        clear_vectors();
        for (int k = 0; k < N_IN; k++) begin
            in_mem[k]   = k + 1;
            w_mem[k][0] = k + 1;
            w_mem[k][1] = -(k + 1);
        end
        bias[0] = 5;
        bias[1] = 5;
        exp_res[0] = act(35);
        exp_res[1] = act(-25);
    endtask

    // Called at a negedge: pulses start this cycle and returns the cycle
    // offset at which out_valid is first seen, or -1 on timeout.
    task automatic run_to_valid(output int cycles);
        cycles = -1;
        start  = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (out_valid) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%0b want=0", busy); end
        tests++; if (adder_rst !== 1'b1) begin fails++; $display("FAIL reset_adder_rst got=%0b want=1", adder_rst); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%0b want=0", done); end
        tests++; if (rd_addr !== '0) begin fails++; $display("FAIL reset_rd_addr got=%0d want=0", rd_addr); end
        for (int j = 0; j < N_OUT; j++) begin
            tests++; if (acc[j] !== 0) begin fails++; $display("FAIL reset_acc[%0d] got=%0d want=0", j, acc[j]); end
            tests++; if (result[j] !== 0) begin fails++; $display("FAIL reset_result[%0d] got=%0d want=0", j, result[j]); end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        load_basic();
        run_to_valid(lat);
        tests++; if (lat !== N_IN + 4) begin fails++; $display("FAIL basic_latency got=%0d want=%0d", lat, N_IN + 4); end
        for (int j = 0; j < N_OUT; j++) begin
            tests++; if (result[j] !== exp_res[j]) begin fails++; $display("FAIL basic_result[%0d] got=%0d want=%0d", j, result[j], exp_res[j]); end
        end
        tests++; if (acc[0] !== 30) begin fails++; $display("FAIL basic_acc0 got=%0d want=30", acc[0]); end
        tests++; if (acc[1] !== -30) begin fails++; $display("FAIL basic_acc1 got=%0d want=-30", acc[1]); end
        tests++; if (adder_rst !== 1'b1) begin fails++; $display("FAIL basic_adder_rst_hold got=%0b want=1", adder_rst); end
        tests++; if (rd_addr !== ADDR_W'(N_IN - 1)) begin fails++; $display("FAIL basic_rd_addr_hold got=%0d want=%0d", rd_addr, N_IN - 1); end
        out_ready = 1'b1;
        #1;
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL basic_done got=%0b want=1", done); end
        @(negedge clk);
        out_ready = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle got=%0b want=0", busy); end
    endtask

    task automatic test_wrap();
        clear_vectors();
        in_mem[0]   = 32'h7FFF_FFFF;
        in_mem[1]   = 1;
        w_mem[0][0] = 2;
        w_mem[0][1] = 3;
        bias[1]     = 1;
        exp_res[0]  = act(-2);
        exp_res[1]  = 32'h7FFF_FFFE;
        run_to_valid(lat);
        tests++; if (lat !== N_IN + 4) begin fails++; $display("FAIL wrap_latency got=%0d want=%0d", lat, N_IN + 4); end
        tests++; if (acc[0] !== 32'hFFFF_FFFE) begin fails++; $display("FAIL wrap_acc0 got=%h want=fffffffe", acc[0]); end
        tests++; if (result[0] !== exp_res[0]) begin fails++; $display("FAIL wrap_result0 got=%0d want=%0d", result[0], exp_res[0]); end
        tests++; if (result[1] !== exp_res[1]) begin fails++; $display("FAIL wrap_result1 got=%h want=%h", result[1], exp_res[1]); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_relu();
        clear_vectors();
        for (int k = 0; k < N_IN; k++) begin
            in_mem[k]   = k + 1;
            w_mem[k][2] = -2;
            w_mem[k][3] = k + 1;
        end
        bias[3] = -10;
        run_to_valid(lat);
        tests++; if (lat !== N_IN + 4) begin fails++; $display("FAIL relu_latency got=%0d want=%0d", lat, N_IN + 4); end
        tests++; if (result[2] !== (RELU ? 0 : -20)) begin fails++; $display("FAIL relu_neg got=%0d want=%0d", result[2], RELU ? 0 : -20); end
        tests++; if (result[3] !== 20) begin fails++; $display("FAIL relu_pos got=%0d want=20", result[3]); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        load_basic();
        run_to_valid(lat);
        tests++; if (lat !== N_IN + 4) begin fails++; $display("FAIL bp_latency got=%0d want=%0d", lat, N_IN + 4); end
        for (int c = 0; c < 5; c++) begin
            start = (c == 1 || c == 3);
            @(negedge clk);
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid c=%0d got=%0b want=1", c, out_valid); end
            tests++; if (done !== 1'b0) begin fails++; $display("FAIL bp_done c=%0d got=%0b want=0", c, done); end
            tests++; if (result[1] !== exp_res[1]) begin fails++; $display("FAIL bp_result1 c=%0d got=%0d want=%0d", c, result[1], exp_res[1]); end
        end
        start     = 1'b0;
        out_ready = 1'b1;
        #1;
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL bp_done_release got=%0b want=1", done); end
        @(negedge clk);
        out_ready = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_idle_after got=%0b want=0", busy); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_valid_after got=%0b want=0", out_valid); end
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_start_ignored got=%0b want=0", busy); end
    endtask

    task automatic test_reset_mid_run();
        bit found;
        load_basic();
        found = 1'b0;
        start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy && rd_addr == 2) begin
                found = 1'b1;
                break;
            end
        end
        tests++; if (found !== 1'b1) begin fails++; $display("FAIL midrun_reach_k2 got=%0b want=1", found); end
        rst = 1'b1;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrun_busy got=%0b want=0", busy); end
        tests++; if (adder_rst !== 1'b1) begin fails++; $display("FAIL midrun_adder_rst got=%0b want=1", adder_rst); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrun_out_valid got=%0b want=0", out_valid); end
        tests++; if (acc[0] !== 0) begin fails++; $display("FAIL midrun_acc0 got=%0d want=0", acc[0]); end
        tests++; if (acc[1] !== 0) begin fails++; $display("FAIL midrun_acc1 got=%0d want=0", acc[1]); end
        rst = 1'b0;
        @(negedge clk);
        run_to_valid(lat);
        tests++; if (lat !== N_IN + 4) begin fails++; $display("FAIL midrun_rerun_latency got=%0d want=%0d", lat, N_IN + 4); end
        tests++; if (result[0] !== exp_res[0]) begin fails++; $display("FAIL midrun_result0 got=%0d want=%0d", result[0], exp_res[0]); end
        tests++; if (result[1] !== exp_res[1]) begin fails++; $display("FAIL midrun_result1 got=%0d want=%0d", result[1], exp_res[1]); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        load_basic();
        out_ready = 1'b1;
        run_to_valid(lat);
        tests++; if (lat !== N_IN + 4) begin fails++; $display("FAIL b2b_first_latency got=%0d want=%0d", lat, N_IN + 4); end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_first_done got=%0b want=1", done); end
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle got=%0b want=0", busy); end
        run_to_valid(lat);
        tests++; if (lat !== N_IN + 4) begin fails++; $display("FAIL b2b_second_latency got=%0d want=%0d", lat, N_IN + 4); end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_second_done got=%0b want=1", done); end
        tests++; if (result[0] !== exp_res[0]) begin fails++; $display("FAIL b2b_result0 got=%0d want=%0d", result[0], exp_res[0]); end
        @(negedge clk);
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_valid_drop got=%0b want=0", out_valid); end
    endtask

    initial begin
        clear_vectors();
        test_reset();
        test_basic();
        test_wrap();
        test_relu();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
